// File: rtl/md_unit.sv
// md_unit: multiply/divide unit beside Execute, owning the architectural HI/LO.
//
// A launched operation computes its 64-bit result at once into res_hi/res_lo.
// The unit then stays busy for MULT_CYCLES or DIV_CYCLES, which models a
// multi-cycle unit for StallControl. At the end of that time the result
// commits to HI/LO.
//
// Ports:
//   clk, reset       rising-edge clock, synchronous active-high reset
//   start, op[2:0]   launch op: 0 MULT 1 MULTU 2 DIV 3 DIVU 4 MADD 5 MADDU 6 MSUB 7 MSUBU
//   rs_val, rt_val   operand A (dividend/multiplicand), operand B (divisor/multiplier)
//   we, wsel         mthi/mtlo write strobe; wsel 1 = HI, 0 = LO (also selects rdata)
//   rdata            combinational wsel ? hi : lo
//   hi, lo           architectural registers
//   busy             operation in flight
//
// Build option: define MD_MADD_EN to implement the accumulate ops (4-7).
// Without it, those ops are accepted as no-ops and the accumulate adder is absent.
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        we,
    input  logic        wsel,
    output logic [31:0] rdata,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy
);
    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [31:0]   res_hi, res_lo;

    logic [63:0]   sprod, uprod, prod, res_nxt;
    logic [31:0]   a_mag, b_mag, q_mag, r_mag, quo, rem;
    logic          is_div, launch;

    assign rdata = wsel ? hi : lo;

    always_comb begin
        sprod  = 64'($signed({{32{rs_val[31]}}, rs_val}) * $signed({{32{rt_val[31]}}, rt_val}));
        uprod  = {32'd0, rs_val} * {32'd0, rt_val};
        prod   = op[0] ? uprod : sprod;
        // Signed divide is done on magnitudes. 0x80000000 / -1 then falls out
        // naturally as quotient 0x80000000, remainder 0.
        a_mag  = (!op[0] && rs_val[31]) ? -rs_val : rs_val;
        b_mag  = (!op[0] && rt_val[31]) ? -rt_val : rt_val;
        q_mag  = (b_mag != 32'd0) ? a_mag / b_mag : 32'd0;
        r_mag  = (b_mag != 32'd0) ? a_mag % b_mag : 32'd0;
        quo    = (!op[0] && (rs_val[31] ^ rt_val[31])) ? -q_mag : q_mag;
        rem    = (!op[0] && rs_val[31]) ? -r_mag : r_mag;
        is_div = op[1] && !op[2];
        res_nxt = {hi, lo};
        if (op[2]) begin
`ifdef MD_MADD_EN
            res_nxt = op[1] ? ({hi, lo} - prod) : ({hi, lo} + prod);
`endif
        end else if (op[1]) begin
            // A zero divisor leaves HI/LO untouched, but the busy time still runs.
            if (rt_val != 32'd0)
                res_nxt = {rem, quo};
        end else begin
            res_nxt = prod;
        end
`ifdef MD_MADD_EN
        launch = 1'b1;
`else
        launch = !op[2];
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            busy   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            res_hi <= '0;
            res_lo <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        // An accepted no-op (accumulate ops when disabled) drops any same-cycle we as well.
                        if (launch) begin
                            {res_hi, res_lo} <= res_nxt;
                            cnt   <= is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                            busy  <= 1'b1;
                            state <= RUN;
                        end
                    end else if (we) begin
                        if (wsel) hi <= rs_val;
                        else      lo <= rs_val;
                    end
                end
                RUN: begin
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        hi    <= res_hi;
                        lo    <= res_lo;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
